// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the sequential signed MULT/DIV unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

  typedef enum logic { OP_MULT = 1'b0, OP_DIV = 1'b1 } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operation context captured at acceptance.
  typedef struct packed {
    op_e  op;
    logic neg_q;   // product / quotient must be negated
    logic neg_r;   // remainder must be negated (dividend sign)
    logic b_zero;  // divisor was zero
  } ctl_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit (master) and the MULT/DIV unit (slave).
interface muldiv_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, a, b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One iteration on the {acc, q} pair: shift-add for MULT, restoring shift-subtract for DIV.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  input  op_e              op,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] add_sel;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] m_ext;

  assign m_ext   = {1'b0, m};
  assign sum     = acc + m_ext;
  assign add_sel = q[0] ? sum : acc;
  assign sh      = {acc[WIDTH-1:0], q[WIDTH-1]};

  always_comb begin
    acc_nxt = acc;
    q_nxt   = q;
    if (op == OP_MULT) begin
      // carry out of the add lands in acc[WIDTH] and shifts down with the pair
      acc_nxt = {1'b0, add_sel[WIDTH:1]};
      q_nxt   = {add_sel[0], q[WIDTH-1:1]};
    end else if (sh >= m_ext) begin
      acc_nxt = sh - m_ext;
      q_nxt   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = sh;
      q_nxt   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV unit: IDLE -> RUN (WIDTH steps) -> FIX -> DONE.
// Build option MULDIV_DIVZERO_TRAP_EN: DIV by zero skips to DONE and pulses div_zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  ctl_t             ctl_q, ctl_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic [WIDTH:0]     step_acc;
  logic [WIDTH-1:0]   step_q;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  op_e                in_op;

  assign in_op  = op_e'(bus.op);
  assign sign_a = bus.a[WIDTH-1];
  assign sign_b = bus.b[WIDTH-1];
  assign mag_a  = sign_a ? -bus.a : bus.a;
  assign mag_b  = sign_b ? -bus.b : bus.b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc_q),
    .q       (qr_q),
    .m       (m_q),
    .op      (ctl_q.op),
    .acc_nxt (step_acc),
    .q_nxt   (step_q)
  );

  assign prod   = {acc_q[WIDTH-1:0], qr_q};
  assign prod_s = ctl_q.neg_q ? -prod : prod;
  assign quo_s  = ctl_q.neg_q ? -qr_q : qr_q;
  // with a zero divisor every trial succeeds, so acc ends up holding |a| and rem_s == a
  assign rem_s  = ctl_q.neg_r ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ctl_d.op     = in_op;
          ctl_d.neg_q  = sign_a ^ sign_b;
          ctl_d.neg_r  = sign_a;
          ctl_d.b_zero = (bus.b == '0);
          cnt_d        = '0;
          acc_d        = '0;
          qr_d         = (in_op == OP_MULT) ? mag_b : mag_a;
          m_d          = (in_op == OP_MULT) ? mag_a : mag_b;
          state_d      = ST_RUN;
`ifdef MULDIV_DIVZERO_TRAP_EN
          if (in_op == OP_DIV && bus.b == '0) state_d = ST_DONE;
`endif
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        qr_d  = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (ctl_q.op == OP_MULT) begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end else begin
          hi_d = rem_s;
          lo_d = ctl_q.b_zero ? '1 : quo_s;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // outputs trail the state by one register stage
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

`ifdef MULDIV_DIVZERO_TRAP_EN
  logic div_zero_q, div_zero_d;
  // only a trapped DIV reaches DONE with b_zero set
  assign div_zero_d = (state_q == ST_DONE) && (ctl_q.op == OP_DIV) && ctl_q.b_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_zero_q <= 1'b0;
    else        div_zero_q <= div_zero_d;
  end
  assign bus.div_zero = div_zero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
